// File: rtl/msrv32_wb_arbiter.sv
// Register-file writeback arbiter: shares the single integer write port
// between the ALU and LSU sources with a valid/ready handshake.
module msrv32_wb_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n_in,
    input  logic        alu_valid_in,
    input  logic [4:0]  alu_rd_addr_in,
    input  logic [31:0] alu_rd_in,
    output logic        alu_ready_out,
    input  logic        lsu_valid_in,
    input  logic [4:0]  lsu_rd_addr_in,
    input  logic [31:0] lsu_rd_in,
    output logic        lsu_ready_out,
    input  logic        flush_in,
    output logic        wr_en_out,
    output logic [4:0]  rd_addr_out,
    output logic [31:0] rd_out,
    output logic [15:0] conflict_cnt_out
);

    typedef enum logic {
        PRI_ALU = 1'b0,
        PRI_LSU = 1'b1
    } pri_state_t;

    pri_state_t  pri_state;
    logic        both_valid;
    logic        grant_alu;
    logic        grant_lsu;
    logic        any_grant;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    assign both_valid = alu_valid_in && lsu_valid_in;

    // Readies are gated by reset too, so nothing handshakes while held in reset.
    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        if (reset_n_in && !flush_in) begin
            if (both_valid) begin
                if (FIXED_PRIO || pri_state == PRI_LSU)
                    grant_lsu = 1'b1;
                else
                    grant_alu = 1'b1;
            end else begin
                grant_alu = alu_valid_in;
                grant_lsu = lsu_valid_in;
            end
        end
    end

    assign any_grant     = grant_alu || grant_lsu;
    assign sel_addr      = grant_lsu ? lsu_rd_addr_in : alu_rd_addr_in;
    assign sel_data      = grant_lsu ? lsu_rd_in      : alu_rd_in;
    assign alu_ready_out = grant_alu;
    assign lsu_ready_out = grant_lsu;

    always_ff @(posedge clock or negedge reset_n_in) begin
        if (!reset_n_in) begin
            pri_state        <= PRI_ALU;
            wr_en_out        <= 1'b0;
            rd_addr_out      <= 5'd0;
            rd_out           <= 32'd0;
            conflict_cnt_out <= 16'd0;
        end else begin
            // x0 writes still complete the handshake but never strobe the port.
            wr_en_out <= any_grant && (sel_addr != 5'd0);
            if (any_grant) begin
                rd_addr_out <= sel_addr;
                rd_out      <= sel_data;
            end
            if (grant_alu)
                pri_state <= PRI_LSU;
            else if (grant_lsu)
                pri_state <= PRI_ALU;
            if (both_valid && !flush_in && conflict_cnt_out != 16'hFFFF)
                conflict_cnt_out <= conflict_cnt_out + 16'd1;
        end
    end

endmodule

// File: doc/msrv32_wb_arbiter.md
MSRV32_WB_ARBITER -- requirements
Module: msrv32_wb_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0: 0 = round-robin between sources; 1 = LSU always wins when both sources request.
REQ-002 clock  input  1  single clock, rising-edge active.
REQ-003 reset_n_in  input  1  asynchronous, active-low reset.
REQ-004 alu_valid_in  input  1  ALU writeback request.
REQ-005 alu_rd_addr_in  input  5  ALU destination register.
REQ-006 alu_rd_in  input  32  ALU result.
REQ-007 alu_ready_out  output  1  ALU request accepted this cycle.
REQ-008 lsu_valid_in  input  1  LSU (load) writeback request.
REQ-009 lsu_rd_addr_in  input  5  LSU destination register.
REQ-010 lsu_rd_in  input  32  LSU load data.
REQ-011 lsu_ready_out  output  1  LSU request accepted this cycle.
REQ-012 flush_in  input  1  pipeline flush; suppresses grants.
REQ-013 wr_en_out  output  1  write enable to integer register file.
REQ-014 rd_addr_out  output  5  write address to integer register file.
REQ-015 rd_out  output  32  write data to integer register file.
REQ-016 conflict_cnt_out  output  16  count of cycles in which both sources requested.

Function
REQ-017 The block SHALL share the single register-file write port between the ALU and LSU sources with a valid/ready handshake; a transfer occurs when valid and ready are both high at a rising edge.
REQ-018 Each source SHALL hold valid, addr and data stable until its ready is seen high.
REQ-019 ready outputs SHALL be combinational from the current valids, priority state and flush_in; at most one ready SHALL be high per cycle.
REQ-020 Only a single requester: that source SHALL be granted.
REQ-021 Both requesting, FIXED_PRIO=0: the grant SHALL follow a 2-state priority FSM: PRI_ALU grants the ALU, PRI_LSU grants the LSU.
REQ-022 FSM transitions: ALU granted -> PRI_LSU; LSU granted -> PRI_ALU; no grant -> hold state.
REQ-023 Both requesting, FIXED_PRIO=1: the LSU SHALL be granted; the FSM SHALL still update per REQ-022 but SHALL not affect the grant.
REQ-024 flush_in high: both readies SHALL be 0, the FSM SHALL hold, and wr_en_out SHALL be 0 on the next cycle.
REQ-025 The granted addr/data SHALL be registered; wr_en_out/rd_addr_out/rd_out SHALL appear exactly 1 cycle after the handshake, and wr_en_out SHALL be high for exactly that one cycle per transfer.
REQ-026 A granted request with rd_addr = 0 SHALL complete its handshake but SHALL drive wr_en_out = 0 (x0 is never written).
REQ-027 With no grant in a cycle, wr_en_out SHALL be 0 the next cycle; rd_addr_out and rd_out SHALL hold their last values.
REQ-028 A loser SHALL be granted no later than the 2nd cycle of continuous requesting under FIXED_PRIO=0 (no starvation).
REQ-029 conflict_cnt_out SHALL increment by 1 in each cycle with both valids high and flush_in low, and SHALL saturate at 16'hFFFF.
REQ-030 Two back-to-back writes to the same rd SHALL reach the register file in grant order.

Reset
REQ-031 While reset_n_in is low, asynchronously: wr_en_out = 0, rd_addr_out = 0, rd_out = 0, conflict_cnt_out = 0, FSM = PRI_ALU.
REQ-032 While reset_n_in is low, alu_ready_out and lsu_ready_out SHALL be 0.
REQ-033 Reset asserted mid-transfer SHALL discard the registered write; no wr_en_out pulse SHALL follow the reset release.
REQ-034 Normal operation SHALL resume on the first rising edge after reset_n_in deasserts.

Verification
REQ-035 ALU only (rd=5, data=32'h0000_00AA) -> alu_ready_out=1 same cycle; next cycle wr_en_out=1, rd_addr_out=5, rd_out=32'hAA.
REQ-036 Both valid for 4 cycles after reset, FIXED_PRIO=0 -> grants ALU, LSU, ALU, LSU; conflict_cnt_out=4.
REQ-037 Both valid, FIXED_PRIO=1 -> LSU granted every cycle while both are valid; ALU granted only once LSU valid drops.
REQ-038 LSU request with rd=0, data=32'hDEAD_BEEF -> lsu_ready_out=1; next cycle wr_en_out=0.
REQ-039 flush_in=1 with both valid -> both readies 0; next cycle wr_en_out=0; FSM unchanged.
REQ-040 Grant at cycle N, then reset_n_in low before edge N+1 -> wr_en_out=0, all outputs 0, FSM=PRI_ALU after release.
